// File: rtl/gray_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter_if
//  Description : Bundle of the gray_counter control, count and decode
//                signals. The slave modport is the counter's view; the
//                master modport is the driver's view.
//                  en, up, load, load_val : count control (master -> slave)
//                  bin_out, gray_out, tc  : registered count state
//                  gray_in                : Gray word to decode
//                  bin_dec                : registered binary decode
//  Revision    : 1.0  initial release
// ============================================================================
interface gray_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_out;
    logic [WIDTH-1:0] gray_out;
    logic             tc;
    logic [WIDTH-1:0] gray_in;
    logic [WIDTH-1:0] bin_dec;

    modport master (
        output en, up, load, load_val, gray_in,
        input  bin_out, gray_out, tc, bin_dec
    );

    modport slave (
        input  en, up, load, load_val, gray_in,
        output bin_out, gray_out, tc, bin_dec
    );
endinterface
`default_nettype wire

// File: rtl/gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : gray_counter
//  Description : Parametrised up/down Gray-code counter with synchronous
//                load, wrap or saturate behaviour at the boundaries and a
//                registered terminal-count flag, plus an independent,
//                fully pipelined Gray-to-binary decode channel.
//                  clk   : rising-edge clock
//                  rst_n : asynchronous active-low reset
//                  bus   : gray_counter_if slave (control, count, decode)
//  Revision    : 1.0  initial release
// ============================================================================
module gray_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  wire               clk,
    input  wire               rst_n,
    gray_counter_if.slave     bus
);

    localparam logic [WIDTH-1:0] c_all_ones = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_one      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_tc;
    logic [WIDTH-1:0] r_dec;

    logic [WIDTH-1:0] w_bin_next;
    logic [WIDTH-1:0] w_gray_next;
    logic             w_tc_next;
    logic [WIDTH-1:0] w_dec_next;

    // Next count and terminal-count flag. Load has priority over counting;
    // a step attempted from a boundary raises tc and either wraps or holds.
    always_comb begin
        w_bin_next = r_bin;
        w_tc_next  = 1'b0;
        if (bus.load) begin
            w_bin_next = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (r_bin == c_all_ones) begin
                    w_tc_next = 1'b1;
                    if (WRAP) begin
                        w_bin_next = '0;
                    end
                end else begin
                    w_bin_next = r_bin + c_one;
                end
            end else begin
                if (r_bin == '0) begin
                    w_tc_next = 1'b1;
                    if (WRAP) begin
                        w_bin_next = c_all_ones;
                    end
                end else begin
                    w_bin_next = r_bin - c_one;
                end
            end
        end
    end

    // Gray is encoded from the next binary value and registered alongside
    // it, so gray_out is glitch-free and always matches bin_out.
    assign w_gray_next = w_bin_next ^ (w_bin_next >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or
    // above it, built as a running prefix from the MSB downwards.
    always_comb begin
        w_dec_next            = '0;
        w_dec_next[WIDTH-1]   = bus.gray_in[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            w_dec_next[i] = w_dec_next[i+1] ^ bus.gray_in[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_tc   <= 1'b0;
            r_dec  <= '0;
        end else begin
            r_bin  <= w_bin_next;
            r_gray <= w_gray_next;
            r_tc   <= w_tc_next;
            r_dec  <= w_dec_next;
        end
    end

    assign bus.bin_out  = r_bin;
    assign bus.gray_out = r_gray;
    assign bus.tc       = r_tc;
    assign bus.bin_dec  = r_dec;

endmodule
`default_nettype wire

// File: tb/tb_gray_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gray_counter
//  Description : Bench for gray_counter. Two instances (WRAP=1, WRAP=0)
//                share one stimulus stream; a reference model pushes the
//                expected outputs per cycle and a monitor compares them.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gray_counter;

    localparam int W   = 4;
    localparam int MAX = (1 << W) - 1;

    logic clk;
    logic rst_n;

    gray_counter_if #(.WIDTH(W)) bus_w ();
    gray_counter_if #(.WIDTH(W)) bus_s ();

    gray_counter #(.WIDTH(W), .WRAP(1'b1)) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w.slave)
    );

    gray_counter #(.WIDTH(W), .WRAP(1'b0)) u_dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] bin;
        logic [W-1:0] gray;
        logic         tc;
        logic [W-1:0] dec;
    } exp_t;

    exp_t q_w[$];
    exp_t q_s[$];

    int vectors    = 0;
    int miscompares = 0;
    int m_cnt[2];        // model count: [0] wrap instance, [1] saturate

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, expv, $time);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Decode by search: the binary word whose Gray encoding equals g.
    function automatic int gray_to_bin(input int g);
        for (int b = 0; b <= MAX; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    function automatic bit model_step(input int k, input bit en, input bit up,
                                      input bit load, input int lv);
        bit wrap = (k == 0);
        bit tc   = 1'b0;
        if (load) begin
            m_cnt[k] = lv;
        end else if (en) begin
            if (up) begin
                if (m_cnt[k] == MAX) begin
                    tc = 1'b1;
                    if (wrap) m_cnt[k] = 0;
                end else begin
                    m_cnt[k] = m_cnt[k] + 1;
                end
            end else begin
                if (m_cnt[k] == 0) begin
                    tc = 1'b1;
                    if (wrap) m_cnt[k] = MAX;
                end else begin
                    m_cnt[k] = m_cnt[k] - 1;
                end
            end
        end
        return tc;
    endfunction

    task automatic drive(input bit en, input bit up, input bit load,
                         input logic [W-1:0] lv, input logic [W-1:0] gi);
        bus_w.en = en; bus_w.up = up; bus_w.load = load; bus_w.load_val = lv; bus_w.gray_in = gi;
        bus_s.en = en; bus_s.up = up; bus_s.load = load; bus_s.load_val = lv; bus_s.gray_in = gi;
    endtask

    // One clocked transaction: drive on the falling edge, push expectations.
    task automatic step(input bit en, input bit up, input bit load,
                        input logic [W-1:0] lv, input logic [W-1:0] gi);
        exp_t e;
        bit   tc;
        @(negedge clk);
        drive(en, up, load, lv, gi);
        for (int k = 0; k < 2; k++) begin
            tc     = model_step(k, en, up, load, int'(lv));
            e.bin  = W'(m_cnt[k]);
            e.gray = W'(to_gray(m_cnt[k]));
            e.tc   = tc;
            e.dec  = W'(gray_to_bin(int'(gi)));
            if (k == 0) q_w.push_back(e);
            else        q_s.push_back(e);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".wrap.bin"},  bus_w.bin_out,  0);
        chk({tag, ".wrap.gray"}, bus_w.gray_out, 0);
        chk({tag, ".wrap.tc"},   bus_w.tc,       0);
        chk({tag, ".wrap.dec"},  bus_w.bin_dec,  0);
        chk({tag, ".sat.bin"},   bus_s.bin_out,  0);
        chk({tag, ".sat.tc"},    bus_s.tc,       0);
    endtask

    // Monitor: one output set per clock, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_w.size() > 0) begin
                e = q_w.pop_front();
                chk("wrap.bin",  bus_w.bin_out,  e.bin);
                chk("wrap.gray", bus_w.gray_out, e.gray);
                chk("wrap.tc",   bus_w.tc,       e.tc);
                chk("wrap.dec",  bus_w.bin_dec,  e.dec);
            end
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                chk("sat.bin",  bus_s.bin_out,  e.bin);
                chk("sat.gray", bus_s.gray_out, e.gray);
                chk("sat.tc",   bus_s.tc,       e.tc);
                chk("sat.dec",  bus_s.bin_dec,  e.dec);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] dec_in [4];
        dec_in[0] = 4'b1000; dec_in[1] = 4'b1111; dec_in[2] = 4'b0000; dec_in[3] = 4'b0110;

        // Reset held with active, arbitrary inputs.
        rst_n = 1'b0;
        m_cnt[0] = 0; m_cnt[1] = 0;
        drive(1'b1, 1'b1, 1'b0, W'($urandom), W'($urandom));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("rst_hold");
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        #1 rst_n = 1'b1;

        // Full up sweep: 16 steps then wrap (saturate on the other instance).
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, 1'b0, '0, W'($urandom));

        // Down saturate from 0, then one step up.
        step(1'b0, 1'b0, 1'b1, 4'b0000, W'($urandom));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, W'($urandom));
        step(1'b1, 1'b1, 1'b0, '0, W'($urandom));

        // Load priority over enable, then boundary step after loading all-ones.
        step(1'b1, 1'b1, 1'b1, 4'b1010, W'($urandom));
        step(1'b1, 1'b1, 1'b1, 4'b1111, W'($urandom));
        step(1'b1, 1'b1, 1'b0, '0, W'($urandom));
        step(1'b1, 1'b1, 1'b0, '0, W'($urandom));

        // Decode sequence while counting.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0, dec_in[i]);

        // Mid-count reset: count to 0111, pulse reset between edges.
        step(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b0, '0, W'($urandom));
        @(posedge clk);
        #2;
        drive(1'b0, 1'b1, 1'b0, '0, '0);
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        m_cnt[0] = 0; m_cnt[1] = 0;
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, '0, W'($urandom));

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
                 W'($urandom), W'($urandom));
        end

        repeat (3) @(posedge clk);
        #3;
        if (q_w.size() != 0 || q_s.size() != 0) begin
            chk("queue_drain", q_w.size() + q_s.size(), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gray_counter.md
# gray_counter

Parametrised Gray-code counter with a registered Gray-to-binary decode channel. It generalises the team's fixed 3-bit combinational binary-to-Gray converter to any WIDTH. It adds up/down counting, synchronous load, wrap/saturate mode and a terminal-count flag. It sits in clock-domain-crossing pointer logic (FIFO read/write pointers) and in position/sequence generators that need single-bit-change outputs.

## Interface
- WIDTH, 4, counter and converter width in bits (legal 2..32)
- WRAP, 1, 1 = modulo-2^WIDTH wrap at boundaries; 0 = saturate at boundaries
- clk  input  1  rising-edge clock, sole clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  count enable; one step per cycle while high
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous load strobe; overrides en
- load_val  input  WIDTH  binary value loaded on load
- bin_out  output  WIDTH  current count, binary, registered
- gray_out  output  WIDTH  current count, Gray-coded, registered
- tc  output  1  terminal-count pulse, registered
- gray_in  input  WIDTH  independent Gray word to decode
- bin_dec  output  WIDTH  binary decode of gray_in, registered

## Operation
- State: one WIDTH-bit binary count register, one WIDTH-bit Gray register, one tc flop and one WIDTH-bit bin_dec register.
- Gray encoding: g = b ^ (b >> 1). It is computed from the next binary value and registered, so bin_out and gray_out always describe the same count in the same cycle. gray_out is never derived combinationally from bin_out.
- Per-edge priority for the count:
  - load=1: count <= load_val, tc <= 0. The en and up inputs are ignored.
  - load=0, en=1, up=1, count != all-ones: count <= count+1, tc <= 0.
  - load=0, en=1, up=0, count != 0: count <= count-1, tc <= 0.
  - load=0, en=1, at boundary (up=1 and count=all-ones, or up=0 and count=0): tc <= 1.
    - WRAP=1: count wraps (all-ones→0, 0→all-ones).
    - WRAP=0: count holds.
  - load=0, en=0: count holds, tc <= 0.
- Arithmetic is unsigned modulo 2^WIDTH. There are no carry-out or borrow ports; tc is the only boundary indication.
- Gray property: with load=0, consecutive gray_out values differ in exactly one bit per step. In WRAP=0 saturation, gray_out is unchanged.
- Decode channel runs independently every cycle, with no enable:
  - bin_dec[WIDTH-1] <= gray_in[WIDTH-1]
  - bin_dec[i] <= bin_dec_next[i+1] ^ gray_in[i], for i = WIDTH-2 down to 0 (prefix XOR from the MSB).
  - The channel is unaffected by load, en or counter state.

## Timing
- Reset (rst_n low, any time, asynchronous): bin_out=0, gray_out=0, tc=0, bin_dec=0. Outputs clear immediately, without waiting for a clock edge.
- Release: the first active edge after rst_n rises acts on inputs normally. Synchronising the deassertion is the integrator's responsibility.
- Count latency: 1 cycle. Inputs sampled at edge N appear on bin_out/gray_out after edge N.
- Load latency: 1 cycle. load_val is visible on both outputs after the edge. tc is 0 in that cycle even if load_val is a boundary value.
- tc is high for exactly one cycle per boundary step. With WRAP=0, en held and at the boundary, tc stays high every cycle.
- Decode latency: 1 cycle, fully pipelined; a new gray_in is accepted every cycle.
- Simultaneous load and en: load wins; no step is taken that cycle.
- Reset mid-count: the count returns to 0 and counting restarts from 0 after release. Any pending tc is dropped.

## Test plan
- Reset: hold rst_n=0 with en=1 and arbitrary inputs -> all outputs 0. Deassert rst_n, then assert it mid-cycle -> outputs clear before the next clk edge.
- Full up sweep, WIDTH=4, WRAP=1, en=1, up=1 from 0 -> gray_out sequence 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000 with tc=1 for one cycle. Each step changes exactly one bit.
- Down saturate, WRAP=0, from count 0: en=1, up=0 for 3 cycles -> bin_out stays 0000, gray_out 0000, tc=1 on all 3 cycles. Then up=1 -> bin_out 0001, tc=0.
- Load priority: load=1, en=1, load_val=4'b1010 -> next cycle bin_out=1010, gray_out=1111, tc=0. Load 4'b1111, then en=1, up=1 -> bin_out=0000, tc=1.
- Decode: gray_in = 1000, 1111, 0000, 0110 on consecutive cycles -> bin_dec = 1111, 1010, 0000, 0100, each one cycle later. Run this while the counter counts, to check independence.
- Mid-count reset: count up to 0111, pulse rst_n low for a half-cycle -> bin_out=0, gray_out=0. Counting resumes 0001, 0010, ... in binary after release.
